onehot_regbank8: RTL and testbench
==================================

Name: onehot_regbank8

Overview:
- 8-entry register bank written through one-hot select lines; sits directly downstream of the 3-to-8 write-address decoder.
- The decoder's 8-bit output drives wr_sel, so the decoder's enable input acts as the write enable.
- Provides two registered read ports, a per-register "written" mask, and a sticky error flag for non-one-hot selects.

Parameters:
- WIDTH, 32, data width of each register.
- ZERO_REG0, 1, when 1 register 0 is hardwired to zero and writes to it are discarded.

Ports:
- clock  input  1  single rising-edge clock.
- resetn  input  1  reset; asynchronous, active-low.
- wr_sel  input  8  one-hot write select from the decoder; all-zero means no write.
- wr_data  input  WIDTH  write data.
- rd_addr_a  input  3  read port A address.
- rd_addr_b  input  3  read port B address.
- rd_data_a  output  WIDTH  registered read data A.
- rd_data_b  output  WIDTH  registered read data B.
- written  output  8  bit k set once register k has been written since reset.
- sel_err  output  1  sticky flag: a non-one-hot select was seen.
- clr_err  input  1  synchronous clear of sel_err.

Behaviour:
- Reset (resetn=0, asynchronous, takes effect immediately): all registers, rd_data_a/b, written and sel_err go to 0. Normal operation resumes on the first rising edge after resetn deasserts.
- Write: at a rising edge where wr_sel has exactly one bit k set, reg[k] <= wr_data and written[k] <= 1.
  - If ZERO_REG0=1 and k=0: no write, written[0] stays 0, no error.
- wr_sel = 0: no write, no error.
- Two or more bits of wr_sel set: no register is written, written is unchanged, and sel_err <= 1 at that edge.
- sel_err stays set until a clock edge with clr_err=1 and no new violation. If a violation and clr_err occur at the same edge, the violation wins and sel_err stays 1.
- Read:
  - rd_data_x <= reg[rd_addr_x] at every rising edge, so latency is 1 cycle from address to data.
  - Address 0 with ZERO_REG0=1 always returns 0.
- Read/write collision (same edge, write target == read address): default is read-before-write, so rd_data returns the old value and the new value is visible on the next read. See BYPASS_EN.
- Both ports may read the same address in the same cycle; both return identical data.
- No backpressure and no stall: one write and two reads per cycle, always accepted.

Optional Feature:
- Macro: ONEHOT_REGBANK_BYPASS_EN.
- Defined: on a read/write collision, the port's rd_data <= wr_data (write-through forwarding).
  - Forwarding is suppressed when the write is discarded: multi-hot select, or register 0 with ZERO_REG0=1.
- Undefined: read-before-write as described under Behaviour; no forwarding logic is built.

Decomposition:
- Shared package:
  - NUM_REGS=8, ADDR_W=3.
  - Type for the 8-bit one-hot select.
  - Function onehot_valid(sel), returning popcount(sel)<=1.
  - Function onehot_index(sel), returning the 3-bit index.
- One sub-module: onehot_check.
  - Input: sel.
  - Outputs: is_zero, is_onehot, is_multi, idx[2:0].
  - Purely combinational; used for write qualification and error detection.

Test Plan:
- Reset then read: hold resetn=0 mid-cycle, release, read addresses 0..7 -> all rd_data=0, written=0x00, sel_err=0. Asserting resetn=0 mid-run zeroes all outputs immediately.
- Single write then read: wr_sel=0x08, wr_data=0xDEADBEEF; next cycle rd_addr_a=3 -> rd_data_a=0xDEADBEEF one cycle later, written=0x08.
- Register 0 with ZERO_REG0=1: wr_sel=0x01, wr_data=0x1234 -> reading address 0 returns 0, written[0]=0, sel_err=0.
- Multi-hot select: preload reg5=0xA5; wr_sel=0x24, wr_data=0xFFFF -> reg2 and reg5 unchanged, sel_err=1.
  - clr_err=1 alone clears it next cycle.
  - clr_err=1 together with wr_sel=0x81 keeps sel_err=1.
- Collision: reg4=0x11; at the same edge wr_sel=0x10, wr_data=0x22, rd_addr_a=4.
  - Without the macro: rd_data_a=0x11, then 0x22 on the next read.
  - With ONEHOT_REGBANK_BYPASS_EN: rd_data_a=0x22 immediately.
- Dual-port same address: rd_addr_a=rd_addr_b=6 after writing 0x66 -> both ports return 0x66 in the same cycle.

Source files
------------

// File: rtl/onehot_regbank8_pkg.sv
// rtl/onehot_regbank8_pkg.sv - shared constants, select type and one-hot helpers for onehot_regbank8
package onehot_regbank8_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;

  typedef logic [NUM_REGS-1:0] sel_t;

  // True when at most one select bit is set (zero counts as valid: no write).
  function automatic logic onehot_valid(input sel_t sel);
    return ($countones(sel) <= 1);
  endfunction

  // Index of the set bit; only meaningful when exactly one bit is set.
  function automatic logic [ADDR_W-1:0] onehot_index(input sel_t sel);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel[i]) idx = i[ADDR_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_regbank8_onehot_check.sv
// rtl/onehot_regbank8_onehot_check.sv - combinational classifier for the one-hot write select
// Ports:
//   sel       in   8-bit write select
//   is_zero   out  no bit set
//   is_onehot out  exactly one bit set
//   is_multi  out  two or more bits set
//   idx       out  index of the set bit (valid when is_onehot)
module onehot_check
  import onehot_regbank8_pkg::*;
(
  input  sel_t              sel,
  output logic              is_zero,
  output logic              is_onehot,
  output logic              is_multi,
  output logic [ADDR_W-1:0] idx
);

  assign is_zero   = (sel == '0);
  assign is_multi  = !onehot_valid(sel);
  assign is_onehot = !is_zero && !is_multi;
  assign idx       = onehot_index(sel);

endmodule

// File: rtl/onehot_regbank8.sv
// rtl/onehot_regbank8.sv - 8-entry register bank with one-hot write select and two registered read ports
// Optional feature macro: ONEHOT_REGBANK_BYPASS_EN (write-through forwarding on read/write collision)
// Ports:
//   clock      in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   wr_sel     in   one-hot write select (all-zero = no write)
//   wr_data    in   write data
//   rd_addr_a  in   read port A address
//   rd_addr_b  in   read port B address
//   rd_data_a  out  registered read data A (1-cycle latency)
//   rd_data_b  out  registered read data B (1-cycle latency)
//   written    out  bit k set once register k has been written since reset
//   sel_err    out  sticky flag for a multi-hot select
//   clr_err    in   synchronous clear of sel_err
module onehot_regbank8
  import onehot_regbank8_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ZERO_REG0 = 1
)(
  input  logic              clock,
  input  logic              resetn,
  input  logic [7:0]        wr_sel,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic [7:0]        written,
  output logic              sel_err,
  input  logic              clr_err
);

  logic [WIDTH-1:0]  regs [NUM_REGS];
  logic              is_zero, is_onehot, is_multi;
  logic [ADDR_W-1:0] idx;
  logic              reg0_drop;
  logic              wr_en;
  logic [WIDTH-1:0]  rd_val_a, rd_val_b;

  onehot_check u_check (
    .sel       (wr_sel),
    .is_zero   (is_zero),
    .is_onehot (is_onehot),
    .is_multi  (is_multi),
    .idx       (idx)
  );

  // Writes to a hardwired-zero register 0 are silently discarded.
  assign reg0_drop = (ZERO_REG0 != 0) && (idx == '0);
  assign wr_en     = is_onehot && !is_zero && !reg0_drop;

  always_comb begin
    rd_val_a = regs[rd_addr_a];
    rd_val_b = regs[rd_addr_b];
    if ((ZERO_REG0 != 0) && (rd_addr_a == '0)) rd_val_a = '0;
    if ((ZERO_REG0 != 0) && (rd_addr_b == '0)) rd_val_b = '0;
  end

`ifdef ONEHOT_REGBANK_BYPASS_EN
  // Forward only writes that actually land; wr_en already excludes discarded ones.
  logic fwd_a, fwd_b;
  assign fwd_a = wr_en && (idx == rd_addr_a);
  assign fwd_b = wr_en && (idx == rd_addr_b);
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
      written   <= '0;
      sel_err   <= 1'b0;
    end else begin
      if (wr_en) begin
        regs[idx]    <= wr_data;
        written[idx] <= 1'b1;
      end
`ifdef ONEHOT_REGBANK_BYPASS_EN
      rd_data_a <= fwd_a ? wr_data : rd_val_a;
      rd_data_b <= fwd_b ? wr_data : rd_val_b;
`else
      rd_data_a <= rd_val_a;
      rd_data_b <= rd_val_b;
`endif
      // A new violation takes priority over a clear on the same edge.
      if (is_multi)     sel_err <= 1'b1;
      else if (clr_err) sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_onehot_regbank8.sv
// tb/tb_onehot_regbank8.sv - randomized self-checking bench for onehot_regbank8 against a behavioural model
module tb_onehot_regbank8;

  logic        clock;
  logic        resetn;
  logic [7:0]  wr_sel;
  logic [31:0] wr_data;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic [7:0]  written;
  logic        sel_err;
  logic        clr_err;

  int tests  = 0;
  int failed = 0;

  // Behavioural model state
  logic [31:0] mem [8];
  logic [7:0]  m_written;
  logic        m_err;
  logic [31:0] exp_a, exp_b;
  bit          bypass;

  onehot_regbank8 #(.WIDTH(32), .ZERO_REG0(1)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .written   (written),
    .sel_err   (sel_err),
    .clr_err   (clr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    m_written = '0;
    m_err     = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the outputs from the model, step the model,
  // and return at posedge+1 with the DUT outputs ready to sample.
  task automatic cycle(input logic [7:0] sel, input logic [31:0] data,
                       input logic [2:0] ra, input logic [2:0] rb, input logic clr);
    int  pc, k;
    bit  lands;
    wr_sel = sel; wr_data = data; rd_addr_a = ra; rd_addr_b = rb; clr_err = clr;
    pc    = $countones(sel);
    k     = (pc == 1) ? $clog2(sel) : 0;
    lands = (pc == 1) && (k != 0);
    exp_a = (ra == 0) ? 32'd0 : mem[ra];
    exp_b = (rb == 0) ? 32'd0 : mem[rb];
    if (bypass && lands && (k == int'(ra))) exp_a = data;
    if (bypass && lands && (k == int'(rb))) exp_b = data;
    if (lands) begin
      mem[k]       = data;
      m_written[k] = 1'b1;
    end
    if (pc > 1)   m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    resetn = 1'b1;
    model_reset();
    for (int a = 0; a < 8; a++) begin
      cycle(8'h00, 32'h0, a[2:0], 3'(7 - a), 1'b0);
      tests++; if (rd_data_a !== 32'd0) begin failed++; $display("FAIL reset_rd_a addr %0d got %h exp 0", a, rd_data_a); end
      tests++; if (rd_data_b !== 32'd0) begin failed++; $display("FAIL reset_rd_b addr %0d got %h exp 0", 7 - a, rd_data_b); end
    end
    tests++; if (written !== 8'h00) begin failed++; $display("FAIL reset_written got %h exp 00", written); end
    tests++; if (sel_err !== 1'b0) begin failed++; $display("FAIL reset_sel_err got %b exp 0", sel_err); end
    // Make outputs non-zero, then assert reset mid-cycle and check without a clock edge.
    cycle(8'h08, 32'h0000ABCD, 3'd0, 3'd0, 1'b0);
    cycle(8'h24, 32'hFFFF, 3'd3, 3'd3, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    tests++; if (rd_data_a !== 32'd0) begin failed++; $display("FAIL async_reset_rd_a got %h exp 0", rd_data_a); end
    tests++; if (rd_data_b !== 32'd0) begin failed++; $display("FAIL async_reset_rd_b got %h exp 0", rd_data_b); end
    tests++; if (written !== 8'h00) begin failed++; $display("FAIL async_reset_written got %h exp 00", written); end
    tests++; if (sel_err !== 1'b0) begin failed++; $display("FAIL async_reset_sel_err got %b exp 0", sel_err); end
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_single_write();
    cycle(8'h08, 32'hDEADBEEF, 3'd0, 3'd0, 1'b0);
    cycle(8'h00, 32'h0, 3'd3, 3'd1, 1'b0);
    tests++; if (rd_data_a !== 32'hDEADBEEF) begin failed++; $display("FAIL single_write_rd got %h exp deadbeef", rd_data_a); end
    tests++; if (written !== 8'h08) begin failed++; $display("FAIL single_write_written got %h exp 08", written); end
  endtask

  task automatic test_reg0();
    cycle(8'h01, 32'h1234, 3'd0, 3'd0, 1'b0);
    cycle(8'h00, 32'h0, 3'd0, 3'd0, 1'b0);
    tests++; if (rd_data_a !== 32'd0) begin failed++; $display("FAIL reg0_read got %h exp 0", rd_data_a); end
    tests++; if (written[0] !== 1'b0) begin failed++; $display("FAIL reg0_written got %b exp 0", written[0]); end
    tests++; if (sel_err !== 1'b0) begin failed++; $display("FAIL reg0_sel_err got %b exp 0", sel_err); end
  endtask

  task automatic test_multi_hot();
    cycle(8'h20, 32'hA5, 3'd0, 3'd0, 1'b0);
    cycle(8'h24, 32'hFFFF, 3'd5, 3'd2, 1'b0);
    tests++; if (sel_err !== 1'b1) begin failed++; $display("FAIL multi_sel_err got %b exp 1", sel_err); end
    tests++; if (written !== 8'h28) begin failed++; $display("FAIL multi_written got %h exp 28", written); end
    cycle(8'h00, 32'h0, 3'd5, 3'd2, 1'b0);
    tests++; if (rd_data_a !== 32'hA5) begin failed++; $display("FAIL multi_reg5 got %h exp a5", rd_data_a); end
    tests++; if (rd_data_b !== 32'd0) begin failed++; $display("FAIL multi_reg2 got %h exp 0", rd_data_b); end
    tests++; if (sel_err !== 1'b1) begin failed++; $display("FAIL multi_sticky got %b exp 1", sel_err); end
    cycle(8'h00, 32'h0, 3'd0, 3'd0, 1'b1);
    tests++; if (sel_err !== 1'b0) begin failed++; $display("FAIL clr_err got %b exp 0", sel_err); end
    cycle(8'h24, 32'hFFFF, 3'd0, 3'd0, 1'b0);
    cycle(8'h81, 32'h77, 3'd7, 3'd0, 1'b1);
    tests++; if (sel_err !== 1'b1) begin failed++; $display("FAIL clr_vs_violation got %b exp 1", sel_err); end
    cycle(8'h00, 32'h0, 3'd7, 3'd0, 1'b1);
    tests++; if (rd_data_a !== 32'd0) begin failed++; $display("FAIL multi_reg7 got %h exp 0", rd_data_a); end
    tests++; if (sel_err !== 1'b0) begin failed++; $display("FAIL clr_after got %b exp 0", sel_err); end
  endtask

  task automatic test_collision();
    cycle(8'h10, 32'h11, 3'd0, 3'd0, 1'b0);
    cycle(8'h10, 32'h22, 3'd4, 3'd0, 1'b0);
    tests++; if (rd_data_a !== (bypass ? 32'h22 : 32'h11)) begin failed++; $display("FAIL collision_first got %h exp %h", rd_data_a, bypass ? 32'h22 : 32'h11); end
    cycle(8'h00, 32'h0, 3'd4, 3'd0, 1'b0);
    tests++; if (rd_data_a !== 32'h22) begin failed++; $display("FAIL collision_next got %h exp 22", rd_data_a); end
    // Discarded multi-hot write must never be forwarded.
    cycle(8'h30, 32'h99, 3'd4, 3'd5, 1'b1);
    tests++; if (rd_data_a !== 32'h22) begin failed++; $display("FAIL collision_multi got %h exp 22", rd_data_a); end
    cycle(8'h00, 32'h0, 3'd0, 3'd0, 1'b1);
  endtask

  task automatic test_dual_port();
    cycle(8'h40, 32'h66, 3'd0, 3'd0, 1'b0);
    cycle(8'h00, 32'h0, 3'd6, 3'd6, 1'b0);
    tests++; if (rd_data_a !== 32'h66) begin failed++; $display("FAIL dual_a got %h exp 66", rd_data_a); end
    tests++; if (rd_data_b !== 32'h66) begin failed++; $display("FAIL dual_b got %h exp 66", rd_data_b); end
  endtask

  task automatic test_random();
    logic [7:0] sel;
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      sel = 8'h01 << $urandom_range(0, 7);
      else if (r < 7) sel = 8'h00;
      else            sel = 8'($urandom);
      cycle(sel, $urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0));
      tests++; if (rd_data_a !== exp_a) begin failed++; $display("FAIL rand_rd_a cyc %0d got %h exp %h", n, rd_data_a, exp_a); end
      tests++; if (rd_data_b !== exp_b) begin failed++; $display("FAIL rand_rd_b cyc %0d got %h exp %h", n, rd_data_b, exp_b); end
      tests++; if (written !== m_written) begin failed++; $display("FAIL rand_written cyc %0d got %h exp %h", n, written, m_written); end
      tests++; if (sel_err !== m_err) begin failed++; $display("FAIL rand_sel_err cyc %0d got %b exp %b", n, sel_err, m_err); end
    end
  endtask

  initial begin
`ifdef ONEHOT_REGBANK_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    resetn = 1'b0; wr_sel = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0; clr_err = 1'b0;
    model_reset();
    test_reset();
    test_single_write();
    test_reg0();
    test_multi_hot();
    test_collision();
    test_dual_port();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
